imem_fill: RTL and testbench

//  Line-fill engine between the L1 instruction cache miss port and the memory bus.

---
 rtl/imem_fill.sv | 110 +++++++++++
 tb/tb_imem_fill.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/imem_fill.sv
// imem_fill: I-cache line-fill engine. Accepts one block-address read from the
// I-cache and issues a single bus read. It gathers LINE_W/BUS_W beats into a
// line and returns that line with a one-cycle valid pulse.
module imem_fill #(
   parameter int LINE_W = 256,
   parameter int BLK_W  = 59,
   parameter int BUS_W  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BLK_W-1:0]  b_addr_i,
   input  logic              b_rd_i,
   output logic [LINE_W-1:0] b_data_i,
   output logic              b_dv_i,
   output logic              fill_err,
   output logic [63:0]       m_addr,
   output logic              m_req,
   input  logic              m_gnt,
   input  logic [BUS_W-1:0]  m_rdata,
   input  logic              m_rvalid,
   input  logic              m_rerr
);

   localparam int BEATS = LINE_W / BUS_W;
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_BEAT, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [BLK_W-1:0]  addr_q;
   logic [CW-1:0]     cnt_q;
   logic              err_q;
   logic              abort_q;
   logic [LINE_W-1:0] line_q;
   logic              beat_last;

   assign beat_last = (state_q == S_BEAT) && m_rvalid && (cnt_q == LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: a grant commits the engine to consuming every beat, even
   // when the cache has already dropped its request
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (b_rd_i) state_d = S_WAIT;
         S_WAIT: state_d = b_rd_i ? S_REQ : S_IDLE;
         S_REQ: begin
            if (m_gnt)        state_d = S_BEAT;
            else if (!b_rd_i) state_d = S_IDLE;
         end
         S_BEAT: if (beat_last) state_d = (abort_q || !b_rd_i) ? S_IDLE : S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state; m_addr stays stable because addr_q only moves in WAIT
   always_comb begin
      m_req    = 1'b0;
      b_dv_i   = 1'b0;
      fill_err = 1'b0;
      m_addr   = {addr_q, {OFF_W{1'b0}}};
      case (state_q)
         S_REQ:  m_req = 1'b1;
         S_DONE: begin
            b_dv_i   = 1'b1;
            fill_err = err_q;
         end
         default: ;
      endcase
   end

   // Datapath: the address is latched in the second request cycle (the cache's
   // address is only settled by then), beats are assembled, and errors and aborts are recorded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
         line_q  <= '0;
      end else begin
         if (state_q == S_WAIT && b_rd_i) addr_q <= b_addr_i;
         if (state_q == S_REQ && m_gnt) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= !b_rd_i;
         end
         if (state_q == S_BEAT) begin
            if (!b_rd_i) abort_q <= 1'b1;
            if (m_rvalid) begin
               for (int b = 0; b < BEATS; b++)
                  if (cnt_q == CW'(b)) line_q[b*BUS_W +: BUS_W] <= m_rdata;
               err_q <= err_q | m_rerr;
               cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            end
         end
      end
   end

   assign b_data_i = line_q;

endmodule

// File: tb/tb_imem_fill.sv
// tb_imem_fill: randomized fills checked by a scoreboard. The stimulus side
// pushes the expected bus address and the expected line, error flag and
// completion cycle. A negedge monitor pops those entries when the DUT
// presents a request, a grant or a line-valid pulse.
module tb_imem_fill;
   localparam int LINE_W = 256;
   localparam int BLK_W  = 59;
   localparam int BUS_W  = 64;
   localparam int BEATS  = LINE_W / BUS_W;

   logic              clk, rst_n;
   logic [BLK_W-1:0]  b_addr;
   logic              b_rd;
   logic [LINE_W-1:0] b_data;
   logic              b_dv, f_err;
   logic [63:0]       m_addr;
   logic              m_req, m_gnt;
   logic [BUS_W-1:0]  m_rdata;
   logic              m_rvalid, m_rerr;

   typedef struct {
      logic [LINE_W-1:0] line;
      logic              err;
      int                cyc;
   } exp_t;

   exp_t        dq[$];
   logic [63:0] aq[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;

   imem_fill #(.LINE_W(LINE_W), .BLK_W(BLK_W), .BUS_W(BUS_W)) dut (
      .clk(clk), .rst_n(rst_n), .b_addr_i(b_addr), .b_rd_i(b_rd),
      .b_data_i(b_data), .b_dv_i(b_dv), .fill_err(f_err), .m_addr(m_addr),
      .m_req(m_req), .m_gnt(m_gnt), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
      .m_rerr(m_rerr));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Monitor: compare whatever the DUT presents against the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_req) begin
            if (aq.size() == 0) chk("req_unexpected", LINE_W'(m_req), LINE_W'(0));
            else                chk("m_addr", LINE_W'(m_addr), LINE_W'(aq[0]));
         end
         if (m_gnt) begin
            chk("req_at_gnt", LINE_W'(m_req), LINE_W'(1));
            if (aq.size() != 0) void'(aq.pop_front());
         end
         if (b_dv) begin
            if (dq.size() == 0) chk("dv_unexpected", LINE_W'(b_dv), LINE_W'(0));
            else begin
               exp_t e;
               e = dq.pop_front();
               chk("line", b_data, e.line);
               chk("fill_err", LINE_W'(f_err), LINE_W'(e.err));
               chk("dv_cycle", LINE_W'(cyc), LINE_W'(e.cyc));
            end
         end
      end
   end

   task automatic chk_zero(input string pfx);
      chk({pfx, "_m_req"}, LINE_W'(m_req), '0);
      chk({pfx, "_m_addr"}, LINE_W'(m_addr), '0);
      chk({pfx, "_b_dv"}, LINE_W'(b_dv), '0);
      chk({pfx, "_fill_err"}, LINE_W'(f_err), '0);
      chk({pfx, "_b_data"}, b_data, '0);
   endtask

   // One fill. a1 is on the bus in the first request cycle and a2 from the second.
   // gd counts stall cycles before the grant. gmax bounds the random idle gaps before each beat.
   // abort_after (>=0) drops b_rd after that beat. rst_after (>=0) pulses reset after that beat.
   task automatic do_fill(input logic [BLK_W-1:0] a1, input logic [BLK_W-1:0] a2,
                          input int gd, input int gmax, input logic [BEATS-1:0] emask,
                          input int abort_after, input int rst_after);
      logic [LINE_W-1:0] line;
      logic [BUS_W-1:0]  d;
      logic              err;
      int                t0, lat;
      int                gaps[BEATS];
      for (int i = 0; i < BEATS; i++) gaps[i] = $urandom_range(gmax, 0);
      @(posedge clk); #1;
      b_rd = 1'b1; b_addr = a1; t0 = cyc;
      @(posedge clk); #1;
      b_addr = a2; aq.push_back({a2, 5'b0});
      @(posedge clk); #1;
      repeat (gd) begin @(posedge clk); #1; end
      m_gnt = 1'b1;
      @(posedge clk); #1;
      m_gnt = 1'b0;
      lat = 3 + gd; err = 1'b0; line = '0;
      for (int i = 0; i < BEATS; i++) begin
         if (abort_after >= 0 && i > abort_after) b_rd = 1'b0;
         if (rst_after >= 0 && i == rst_after + 1) begin
            m_rvalid = 1'b0;
            #2 rst_n = 1'b0; b_rd = 1'b0;
            #1 chk_zero("rst_mid");
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
         repeat (gaps[i]) begin m_rvalid = 1'b0; @(posedge clk); #1; end
         d = {$urandom, $urandom};
         m_rvalid = 1'b1; m_rdata = d; m_rerr = emask[i];
         line[i*BUS_W +: BUS_W] = d; err |= emask[i]; lat += gaps[i] + 1;
         @(posedge clk); #1;
      end
      m_rvalid = 1'b0; m_rerr = 1'b0;
      if (abort_after < 0 && rst_after < 0) begin
         dq.push_back('{line, err, t0 + lat});
         @(posedge clk); #1;
         b_rd = 1'b0;
      end else begin
         b_rd = 1'b0;
         @(posedge clk); #1;
      end
      if (rst_after >= 0) chk("stray_beats_dropped", b_data, '0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; b_addr = '0; b_rd = 1'b0; m_gnt = 1'b0;
      m_rdata = '0; m_rvalid = 1'b0; m_rerr = 1'b0;
      #2 chk_zero("reset");
      #20;
      @(negedge clk) rst_n = 1'b1;
      // basic fill, latency 7
      do_fill(59'h100, 59'h100, 0, 0, '0, -1, -1);
      // address taken from the second request cycle -> 0x400
      do_fill(59'h10, 59'h20, 0, 0, '0, -1, -1);
      // grant stall plus beat gaps
      do_fill(59'h3, 59'h3, 5, 2, '0, -1, -1);
      // error on beat 2, then a clean fill
      do_fill(59'h44, 59'h44, 0, 0, 4'b0100, -1, -1);
      do_fill(59'h45, 59'h45, 1, 1, '0, -1, -1);
      // abort after beat 1, then a normal fill
      do_fill(59'h50, 59'h50, 0, 1, '0, 1, -1);
      do_fill(59'h51, 59'h51, 0, 0, '0, -1, -1);
      // reset during BEAT, then a normal fill
      do_fill(59'h60, 59'h60, 0, 0, '0, -1, 1);
      do_fill(59'h61, 59'h61, 0, 0, '0, -1, -1);
      // randomized fills
      for (int n = 0; n < 25; n++) begin
         logic [BLK_W-1:0] a;
         logic [BEATS-1:0] em;
         int ab;
         a  = BLK_W'({$urandom, $urandom});
         em = ($urandom_range(3, 0) == 0) ? BEATS'($urandom) : '0;
         ab = ($urandom_range(7, 0) == 0) ? int'($urandom_range(BEATS - 2, 0)) : -1;
         do_fill(BLK_W'($urandom), a, $urandom_range(3, 0), $urandom_range(2, 0), em, ab, -1);
      end
      repeat (5) @(posedge clk);
      #1;
      chk("addr_queue_empty", LINE_W'(aq.size()), '0);
      chk("line_queue_empty", LINE_W'(dq.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
